// File: rtl/product_accumulator_if.sv
// product_accumulator_if
//   Groups the two valid/ready channels of the product accumulator.
//   Input channel : in_valid, in_ready, in_product (PROD_W bits)
//   Output channel: out_valid, out_ready, out_sum (SUM_W bits), out_ovf
//   master : the producer/consumer environment around the accumulator
//   slave  : the accumulator itself
interface product_accumulator_if #(
  parameter int PROD_W = 4,
  parameter int SUM_W  = 8
);
  logic              in_valid;
  logic              in_ready;
  logic [PROD_W-1:0] in_product;
  logic              out_valid;
  logic              out_ready;
  logic [SUM_W-1:0]  out_sum;
  logic              out_ovf;

  modport master (
    output in_valid, in_product, out_ready,
    input  in_ready, out_valid, out_sum, out_ovf
  );

  modport slave (
    input  in_valid, in_product, out_ready,
    output in_ready, out_valid, out_sum, out_ovf
  );
endinterface

// File: rtl/product_accumulator.sv
// product_accumulator
//   Sums COUNT unsigned products (from a 2-bit x 2-bit multiplier) received
//   over a valid/ready handshake and presents the wrapped sum plus a sticky
//   carry-out flag on a valid/ready output. Accumulate half of a small MAC.
// Ports
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset, drops all state immediately
//   clear  : synchronous abort of the current batch and any held result
//   bus    : product_accumulator_if.slave
//            in_valid/in_ready/in_product  - product input channel
//            out_valid/out_ready/out_sum/out_ovf - result output channel
module product_accumulator #(
  parameter int PROD_W = 4,
  parameter int COUNT  = 4,
  parameter int SUM_W  = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  product_accumulator_if.slave bus
);

  localparam int CNT_W = (COUNT > 1) ? $clog2(COUNT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(COUNT - 1);

  typedef enum logic [0:0] {
    S_ACC = 1'b0,
    S_OUT = 1'b1
  } state_t;

  state_t             state_r, state_s;
  logic [SUM_W-1:0]   acc_r, acc_s;
  logic [CNT_W-1:0]   cnt_r, cnt_s;
  logic               ovf_r, ovf_s;
  logic [SUM_W-1:0]   out_sum_r, out_sum_s;
  logic               out_ovf_r, out_ovf_s;
  logic               out_valid_r, out_valid_s;
  logic               in_ready_s;
  logic               accept_s;
  logic [SUM_W:0]     sum_s;

  // Zero-extended add; bit SUM_W is the carry out of the accumulator width.
  function automatic logic [SUM_W:0] add_with_carry(
    input logic [SUM_W-1:0]  a,
    input logic [PROD_W-1:0] p
  );
    return {1'b0, a} + {{(SUM_W + 1 - PROD_W){1'b0}}, p};
  endfunction

  // Ready is a pure function of the state register, never of in_valid/out_ready.
  assign in_ready_s = (state_r == S_ACC);
  assign accept_s   = bus.in_valid & in_ready_s;
  assign sum_s      = add_with_carry(acc_r, bus.in_product);

  assign bus.in_ready  = in_ready_s;
  assign bus.out_valid = out_valid_r;
  assign bus.out_sum   = out_sum_r;
  assign bus.out_ovf   = out_ovf_r;

  // Next-state and datapath update for the collect/hold FSM.
  always_comb begin
    state_s     = state_r;
    acc_s       = acc_r;
    cnt_s       = cnt_r;
    ovf_s       = ovf_r;
    out_sum_s   = out_sum_r;
    out_ovf_s   = out_ovf_r;
    out_valid_s = out_valid_r;

    if (clear) begin
      // Abort wins over any handshake; the held result need not be zeroed.
      state_s     = S_ACC;
      acc_s       = {SUM_W{1'b0}};
      cnt_s       = {CNT_W{1'b0}};
      ovf_s       = 1'b0;
      out_valid_s = 1'b0;
    end else begin
      case (state_r)
        S_ACC: begin
          if (accept_s) begin
            if (cnt_r == CNT_LAST) begin
              // Last product of the batch: publish and restart the batch.
              out_sum_s   = sum_s[SUM_W-1:0];
              out_ovf_s   = ovf_r | sum_s[SUM_W];
              out_valid_s = 1'b1;
              state_s     = S_OUT;
              acc_s       = {SUM_W{1'b0}};
              cnt_s       = {CNT_W{1'b0}};
              ovf_s       = 1'b0;
            end else begin
              acc_s = sum_s[SUM_W-1:0];
              ovf_s = ovf_r | sum_s[SUM_W];
              cnt_s = cnt_r + CNT_W'(1);
            end
          end else begin
            state_s = S_ACC;
          end
        end
        S_OUT: begin
          if (out_valid_r && bus.out_ready) begin
            out_valid_s = 1'b0;
            state_s     = S_ACC;
          end else begin
            state_s = S_OUT;
          end
        end
        default: begin
          state_s     = S_ACC;
          acc_s       = {SUM_W{1'b0}};
          cnt_s       = {CNT_W{1'b0}};
          ovf_s       = 1'b0;
          out_valid_s = 1'b0;
        end
      endcase
    end
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= S_ACC;
      acc_r       <= {SUM_W{1'b0}};
      cnt_r       <= {CNT_W{1'b0}};
      ovf_r       <= 1'b0;
      out_sum_r   <= {SUM_W{1'b0}};
      out_ovf_r   <= 1'b0;
      out_valid_r <= 1'b0;
    end else begin
      state_r     <= state_s;
      acc_r       <= acc_s;
      cnt_r       <= cnt_s;
      ovf_r       <= ovf_s;
      out_sum_r   <= out_sum_s;
      out_ovf_r   <= out_ovf_s;
      out_valid_r <= out_valid_s;
    end
  end

endmodule

// File: tb/tb_product_accumulator.sv
// Testbench for product_accumulator: an 8-bit-sum instance and a 5-bit-sum
// instance (for carry-out behaviour). Expected results are queued when a
// batch is issued and popped by per-instance monitors on each output handshake.
module tb_product_accumulator;

  logic clk;
  logic rst_n;
  logic clear;

  int n_checks;
  int n_fail;

  typedef struct {
    logic [7:0] sum;
    logic       ovf;
  } exp_t;

  exp_t q8[$];
  exp_t q5[$];

  product_accumulator_if #(.PROD_W(4), .SUM_W(8)) bus8 ();
  product_accumulator_if #(.PROD_W(4), .SUM_W(5)) bus5 ();

  product_accumulator #(.PROD_W(4), .COUNT(4), .SUM_W(8)) dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (clear),
    .bus   (bus8)
  );

  product_accumulator #(.PROD_W(4), .COUNT(4), .SUM_W(5)) dut5 (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (clear),
    .bus   (bus5)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Offer one product and hold it until accepted (bounded wait).
  task automatic send(input bit sel5, input logic [3:0] p);
    int budget;
    budget = 0;
    @(negedge clk);
    if (sel5) begin bus5.in_valid = 1'b1; bus5.in_product = p; end
    else      begin bus8.in_valid = 1'b1; bus8.in_product = p; end
    while (((sel5 ? bus5.in_ready : bus8.in_ready) !== 1'b1) && budget < 40) begin
      @(negedge clk);
      budget++;
    end
    if (budget >= 40) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_timeout: in_ready never 1 for product %0d", p);
    end
    @(posedge clk);
    #1;
    if (sel5) bus5.in_valid = 1'b0;
    else      bus8.in_valid = 1'b0;
  endtask

  task automatic push8(input logic [7:0] s, input logic o);
    exp_t e;
    e.sum = s; e.ovf = o;
    q8.push_back(e);
  endtask

  task automatic push5(input logic [7:0] s, input logic o);
    exp_t e;
    e.sum = s; e.ovf = o;
    q5.push_back(e);
  endtask

  // Wait until the 8-bit instance has no result pending (bounded).
  task automatic wait_drained8();
    int budget;
    budget = 0;
    @(negedge clk);
    while (bus8.out_valid === 1'b1 && budget < 40) begin
      @(negedge clk);
      budget++;
    end
    if (budget >= 40) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain8_timeout: out_valid stuck at 1");
    end
  endtask

  // Scoreboard monitor for the 8-bit instance.
  always @(negedge clk) begin : mon8
    exp_t e;
    if (rst_n && bus8.out_valid && bus8.out_ready) begin
      if (q8.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_out8: sum %0d with empty scoreboard", bus8.out_sum);
      end else begin
        e = q8.pop_front();
        check("sum8", 32'(bus8.out_sum), 32'(e.sum));
        check("ovf8", 32'(bus8.out_ovf), 32'(e.ovf));
      end
    end
  end

  // Scoreboard monitor for the 5-bit instance.
  always @(negedge clk) begin : mon5
    exp_t e;
    if (rst_n && bus5.out_valid && bus5.out_ready) begin
      if (q5.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_out5: sum %0d with empty scoreboard", bus5.out_sum);
      end else begin
        e = q5.pop_front();
        check("sum5", 32'(bus5.out_sum), 32'(e.sum));
        check("ovf5", 32'(bus5.out_ovf), 32'(e.ovf));
      end
    end
  end

  initial begin
    int budget;
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    clear    = 1'b0;
    bus8.in_valid = 1'b0; bus8.in_product = 4'd0; bus8.out_ready = 1'b1;
    bus5.in_valid = 1'b0; bus5.in_product = 4'd0; bus5.out_ready = 1'b1;

    // Reset state
    #12;
    check("rst_out_valid", 32'(bus8.out_valid), 32'd0);
    check("rst_out_sum",   32'(bus8.out_sum),   32'd0);
    check("rst_out_ovf",   32'(bus8.out_ovf),   32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_in_ready", 32'(bus8.in_ready), 32'd1);

    // Basic batch 9,9,9,9 -> 36, latency 1
    push8(8'd36, 1'b0);
    send(1'b0, 4'd9); send(1'b0, 4'd9); send(1'b0, 4'd9);
    check("basic_no_early_valid", 32'(bus8.out_valid), 32'd0);
    send(1'b0, 4'd9);
    check("basic_valid_latency", 32'(bus8.out_valid), 32'd1);
    wait_drained8();

    // Reset while a result is held drops it at once
    bus8.out_ready = 1'b0;
    send(1'b0, 4'd2); send(1'b0, 4'd2); send(1'b0, 4'd2); send(1'b0, 4'd2);
    @(negedge clk);
    check("hold_before_reset", 32'(bus8.out_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    check("midhold_rst_valid", 32'(bus8.out_valid), 32'd0);
    check("midhold_rst_sum",   32'(bus8.out_sum),   32'd0);
    check("midhold_rst_ovf",   32'(bus8.out_ovf),   32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("post_rst_in_ready", 32'(bus8.in_ready), 32'd1);

    // Reset mid-batch: partial sum must not leak into the next batch
    bus8.out_ready = 1'b1;
    send(1'b0, 4'd7); send(1'b0, 4'd7);
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    push8(8'd10, 1'b0);
    send(1'b0, 4'd1); send(1'b0, 4'd2); send(1'b0, 4'd3); send(1'b0, 4'd4);
    wait_drained8();

    // Backpressure: 1,2,3,0 held for 5 cycles with a product offered
    bus8.out_ready = 1'b0;
    push8(8'd6, 1'b0);
    send(1'b0, 4'd1); send(1'b0, 4'd2); send(1'b0, 4'd3); send(1'b0, 4'd0);
    bus8.in_valid = 1'b1;
    bus8.in_product = 4'd15;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_out_valid", 32'(bus8.out_valid), 32'd1);
      check("bp_out_sum",   32'(bus8.out_sum),   32'd6);
      check("bp_in_ready",  32'(bus8.in_ready),  32'd0);
    end
    bus8.in_valid = 1'b0;
    bus8.out_ready = 1'b1;
    wait_drained8();
    push8(8'd16, 1'b0);
    send(1'b0, 4'd4); send(1'b0, 4'd4); send(1'b0, 4'd4); send(1'b0, 4'd4);
    wait_drained8();

    // Gapped input 3,1,2,2 -> 8
    push8(8'd8, 1'b0);
    send(1'b0, 4'd3); @(negedge clk);
    send(1'b0, 4'd1); @(negedge clk);
    send(1'b0, 4'd2); @(negedge clk);
    send(1'b0, 4'd2);
    wait_drained8();

    // Clear after two accepts, with a product offered in the clear cycle
    send(1'b0, 4'd5); send(1'b0, 4'd5);
    @(negedge clk);
    clear = 1'b1;
    bus8.in_valid = 1'b1;
    bus8.in_product = 4'd9;
    @(posedge clk);
    #1;
    clear = 1'b0;
    bus8.in_valid = 1'b0;
    push8(8'd4, 1'b0);
    send(1'b0, 4'd1); send(1'b0, 4'd1); send(1'b0, 4'd1); send(1'b0, 4'd1);
    wait_drained8();

    // Clear while a result is held
    bus8.out_ready = 1'b0;
    send(1'b0, 4'd2); send(1'b0, 4'd2); send(1'b0, 4'd2); send(1'b0, 4'd2);
    @(negedge clk);
    check("clr_hold_valid", 32'(bus8.out_valid), 32'd1);
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
    check("clr_drops_valid", 32'(bus8.out_valid), 32'd0);
    check("clr_in_ready",    32'(bus8.in_ready),  32'd1);
    bus8.out_ready = 1'b1;

    // Overflow on the 5-bit instance, then sticky flag cleared for next batch
    push5(8'd4, 1'b1);
    send(1'b1, 4'd9); send(1'b1, 4'd9); send(1'b1, 4'd9); send(1'b1, 4'd9);
    push5(8'd4, 1'b0);
    send(1'b1, 4'd1); send(1'b1, 4'd1); send(1'b1, 4'd1); send(1'b1, 4'd1);

    // Let the scoreboards drain
    budget = 0;
    while ((q8.size() != 0 || q5.size() != 0) && budget < 50) begin
      @(negedge clk);
      budget++;
    end
    #1;
    check("sb8_drained", 32'(q8.size()), 32'd0);
    check("sb5_drained", 32'(q5.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
